// File: rtl/apb_req_arbiter.sv
`default_nettype none
// apb_req_arbiter: round-robin sharing of one APB master among NUM_REQ requesters,
// one transfer in flight, completion detected on the bus.  Rev 1.0
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int PROT_WIDTH = 3
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
  input  logic [NUM_REQ*PROT_WIDTH-1:0]    req_prot,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             slverr,
  output logic                             busy,
  output logic                             transfer,
  output logic                             SWRITE,
  output logic [ADDR_WIDTH-1:0]            SADDR,
  output logic [DATA_WIDTH-1:0]            SWDATA,
  output logic [STRB_WIDTH-1:0]            SSTRB,
  output logic [PROT_WIDTH-1:0]            SPROT,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PREADY,
  input  logic                             PSLVERR,
  input  logic [DATA_WIDTH-1:0]            PRDATA
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [IW:0]        NREQ = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0]      LAST = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);

  logic [1:0]           state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        win;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IW-1:0]        offset;
  logic [IW:0]          sum;
  logic [IW-1:0]        sel;

  // Rotate requests so the pointer lands at bit 0; lowest set bit is the winner's distance.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    offset  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = IW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= NREQ) sum = sum - NREQ;
    sel = sum[IW-1:0];
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state  <= ST_ARB;
      ptr    <= '0;
      win    <= '0;
      gnt    <= '0;
      SWRITE <= 1'b0;
      SADDR  <= '0;
      SWDATA <= '0;
      SSTRB  <= '0;
      SPROT  <= '0;
      rdata  <= '0;
      slverr <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          if (|req) begin
            win    <= sel;
            gnt    <= ONE << sel;
            SWRITE <= req_write[sel];
            SADDR  <= req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            SWDATA <= req_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
            SSTRB  <= req_strb[sel*STRB_WIDTH +: STRB_WIDTH];
            SPROT  <= req_prot[sel*PROT_WIDTH +: PROT_WIDTH];
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (PSEL && PENABLE && PREADY) begin
            rdata  <= PRDATA;
            slverr <= PSLVERR;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt   <= '0;
          ptr   <= (win == LAST) ? '0 : win + IW'(1);
          state <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  assign busy     = (state != ST_ARB);
  assign transfer = (state == ST_ISSUE);
  assign done     = (state == ST_DONE) ? gnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// tb_apb_req_arbiter: vector table, hand sequences and randomized traffic against a
// transaction-level round-robin model; the bench also plays the APB master and slave.
module tb_apb_req_arbiter;

  localparam int N = 4;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic [N-1:0]  req;
  logic [N-1:0]  req_write;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_strb;
  logic [N*3-1:0]  req_prot;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic [31:0]   rdata;
  logic          slverr;
  logic          busy;
  logic          transfer;
  logic          SWRITE;
  logic [31:0]   SADDR;
  logic [31:0]   SWDATA;
  logic [3:0]    SSTRB;
  logic [2:0]    SPROT;
  logic          PSEL;
  logic          PENABLE;
  logic          PREADY;
  logic          PSLVERR;
  logic [31:0]   PRDATA;

  logic          f_write [N];
  logic [31:0]   f_addr  [N];
  logic [31:0]   f_wdata [N];
  logic [3:0]    f_strb  [N];
  logic [2:0]    f_prot  [N];

  int            m_waits;
  logic [31:0]   m_prdata;
  logic          m_err;
  bit            m_spurious;
  int            m_ptr;
  logic [31:0]   last_rd;
  logic          last_err;
  int            n_cmp;
  int            n_bad;

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] prd;
    logic        perr;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [6];

  apb_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .PROT_WIDTH(3)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_strb(req_strb), .req_prot(req_prot),
    .gnt(gnt), .done(done), .rdata(rdata), .slverr(slverr), .busy(busy),
    .transfer(transfer), .SWRITE(SWRITE), .SADDR(SADDR), .SWDATA(SWDATA),
    .SSTRB(SSTRB), .SPROT(SPROT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial forever #5 PCLK = ~PCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always_comb begin
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    for (int i = 0; i < N; i++) begin
      req_write[i]        = f_write[i];
      req_addr[i*32 +: 32]  = f_addr[i];
      req_wdata[i*32 +: 32] = f_wdata[i];
      req_strb[i*4 +: 4]    = f_strb[i];
      req_prot[i*3 +: 3]    = f_prot[i];
    end
  end

  // APB master/slave stand-in: SETUP after transfer, then ACCESS with m_waits not-ready cycles.
  initial begin : bus
    logic n_sel, n_en, n_rdy, n_real;
    int   cnt;
    PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    cnt = 0;
    forever begin
      @(negedge PCLK);
      n_sel = 1'b0; n_en = 1'b0; n_rdy = 1'b0; n_real = 1'b0;
      if (PSEL && !PENABLE) begin
        n_sel = 1'b1; n_en = 1'b1; cnt = m_waits; n_rdy = (cnt <= 0); n_real = n_rdy;
      end else if (PSEL && PENABLE && !PREADY) begin
        n_sel = 1'b1; n_en = 1'b1; cnt--; n_rdy = (cnt <= 0); n_real = n_rdy;
      end else if (transfer) begin
        n_sel = 1'b1; n_rdy = 1'($urandom());
      end else if (m_spurious) begin
        n_sel = 1'b1; n_en = 1'b1; n_rdy = 1'b1;
      end
      @(posedge PCLK);
      #1;
      if (PRESET) begin
        PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      end else begin
        PSEL    = n_sel;
        PENABLE = n_en;
        PREADY  = n_rdy;
        PRDATA  = n_real ? m_prdata : $urandom();
        PSLVERR = n_real ? m_err : 1'($urandom());
      end
    end
  end

  function automatic logic [N-1:0] onehot(input int i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    f_write[i] = wr;
    f_addr[i]  = a;
    f_wdata[i] = d;
    f_strb[i]  = s;
    f_prot[i]  = p;
    req[i]     = 1'b1;
  endtask

  // Entered at the falling edge of an ARB cycle with requests already driven; returns at
  // the falling edge of the following ARB cycle.
  task automatic serve(input int w, input int waits, input logic [31:0] prd, input logic perr,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                       input bit drop_mid, input bit keep);
    logic        sw;
    logic [31:0] sa, sd;
    logic [3:0]  ss;
    logic [2:0]  sp;
    int          n;
    bit          hold;
    m_waits = waits; m_prdata = prd; m_err = perr;
    sw = f_write[w]; sa = f_addr[w]; sd = f_wdata[w]; ss = f_strb[w]; sp = f_prot[w];
    @(negedge PCLK);
    chk("issue_ctl", 64'({gnt, transfer, busy, done}), 64'({onehot(w), 1'b1, 1'b1, 4'b0}));
    chk("issue_addr", 64'(SADDR), 64'(sa));
    chk("issue_wdata", 64'(SWDATA), 64'(sd));
    chk("issue_attr", 64'({SWRITE, SSTRB, SPROT}), 64'({sw, ss, sp}));
    n = 1;
    hold = 1'b1;
    while (n < 30) begin
      @(negedge PCLK);
      n++;
      if (n == 2 && drop_mid) begin
        req[w] = 1'b0; f_addr[w] = ~sa; f_wdata[w] = ~sd; f_write[w] = ~sw;
      end
      if (done != '0) break;
      if (transfer || !busy || gnt != onehot(w) || SADDR != sa || SWDATA != sd ||
          {SWRITE, SSTRB, SPROT} != {sw, ss, sp}) hold = 1'b0;
    end
    chk("wait_hold", 64'(hold), 64'(1));
    chk("latency", 64'(n), 64'(exp_lat));
    chk("done", 64'({done, gnt, busy}), 64'({onehot(w), onehot(w), 1'b1}));
    chk("rdata", 64'(rdata), 64'(exp_rd));
    chk("slverr", 64'(slverr), 64'(exp_err));
    if (!keep) req[w] = 1'b0;
    m_ptr = (w + 1) % N;
    last_rd = exp_rd;
    last_err = exp_err;
    @(negedge PCLK);
    chk("arb_idle", 64'({gnt, done, busy, transfer}), 64'(0));
    chk("rdata_hold", 64'({slverr, rdata}), 64'({exp_err, exp_rd}));
  endtask

  initial begin
    int w, waits;
    logic [31:0] prd;
    logic perr;
    bit drop, keep;

    n_cmp = 0; n_bad = 0; m_waits = 0; m_prdata = '0; m_err = 1'b0; m_spurious = 1'b0;
    m_ptr = 0; last_rd = '0; last_err = 1'b0; req = '0;
    for (int i = 0; i < N; i++) begin
      f_write[i] = 1'b0; f_addr[i] = '0; f_wdata[i] = '0; f_strb[i] = '0; f_prot[i] = '0;
    end

    tbl[0] = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 3'h0, 0, 32'hA5A5_A5A5, 1'b0, 4, 32'hA5A5_A5A5, 1'b0};
    tbl[1] = '{1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 3'h2, 3, 32'h1234_5678, 1'b0, 7, 32'h1234_5678, 1'b0};
    tbl[2] = '{2, 1'b0, 32'h0000_0300, 32'h0000_0000, 4'h1, 3'h1, 0, 32'hCAFE_F00D, 1'b1, 4, 32'hCAFE_F00D, 1'b1};
    tbl[3] = '{3, 1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, 3'h7, 1, 32'h0000_0001, 1'b0, 5, 32'h0000_0001, 1'b0};
    tbl[4] = '{0, 1'b1, 32'hFFFF_FFFC, 32'h55AA_55AA, 4'hC, 3'h5, 2, 32'h8000_0000, 1'b1, 6, 32'h8000_0000, 1'b1};
    tbl[5] = '{3, 1'b0, 32'h8000_0000, 32'h0000_0000, 4'h3, 3'h4, 4, 32'hFFFF_FFFF, 1'b0, 8, 32'hFFFF_FFFF, 1'b0};

    repeat (3) @(negedge PCLK);
    chk("rst_ctl", 64'({gnt, done, busy, transfer, SWRITE, slverr}), 64'(0));
    chk("rst_saddr", 64'(SADDR), 64'(0));
    chk("rst_swdata", 64'({SWDATA, SSTRB, SPROT}), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    PRESET = 1'b0;

    // All four requesting from pointer 0; requester 0 keeps asking and comes round again.
    for (int i = 0; i < N; i++) load(i, 1'(i), 32'h100 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF, 3'(i));
    serve(0, 0, 32'h0000_0A00, 1'b0, 4, 32'h0000_0A00, 1'b0, 1'b0, 1'b1);
    serve(1, 1, 32'h0000_0A01, 1'b0, 5, 32'h0000_0A01, 1'b0, 1'b0, 1'b0);
    serve(2, 0, 32'h0000_0A02, 1'b1, 4, 32'h0000_0A02, 1'b1, 1'b0, 1'b0);
    serve(3, 2, 32'h0000_0A03, 1'b0, 6, 32'h0000_0A03, 1'b0, 1'b0, 1'b0);
    serve(0, 0, 32'h0000_0A04, 1'b0, 4, 32'h0000_0A04, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      load(tbl[t].idx, tbl[t].wr, tbl[t].addr, tbl[t].wdata, tbl[t].strb, tbl[t].prot);
      serve(tbl[t].idx, tbl[t].waits, tbl[t].prd, tbl[t].perr, tbl[t].exp_lat,
            tbl[t].exp_rd, tbl[t].exp_err, 1'b0, 1'b0);
    end

    // Bus handshakes while idle must not disturb anything.
    m_spurious = 1'b1;
    repeat (4) @(negedge PCLK);
    chk("spurious", 64'({busy, done, gnt, slverr, rdata}), 64'({1'b0, 4'b0, 4'b0, last_err, last_rd}));
    m_spurious = 1'b0;
    repeat (2) @(negedge PCLK);

    // Requester 2 withdraws mid-transfer: still completes, never re-granted.
    load(2, 1'b0, 32'h0000_0222, 32'h0, 4'hF, 3'h2);
    serve(2, 2, 32'h2222_2222, 1'b0, 6, 32'h2222_2222, 1'b0, 1'b1, 1'b0);
    @(negedge PCLK);
    chk("no_regrant", 64'({busy, gnt, done}), 64'(0));

    // Reset while waiting on a slow slave.
    load(1, 1'b1, 32'h0000_1110, 32'h1357_9BDF, 4'hA, 3'h3);
    m_waits = 6; m_prdata = 32'h7777_7777; m_err = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("pre_rst_busy", 64'({busy, gnt}), 64'({1'b1, 4'b0010}));
    PRESET = 1'b1;
    #1;
    chk("midrst_ctl", 64'({gnt, done, busy, transfer, SWRITE, slverr}), 64'(0));
    chk("midrst_saddr", 64'(SADDR), 64'(0));
    chk("midrst_swdata", 64'({SWDATA, SSTRB, SPROT}), 64'(0));
    chk("midrst_rdata", 64'(rdata), 64'(0));
    repeat (2) @(negedge PCLK);
    chk("midrst_nodone", 64'({done, busy, gnt}), 64'(0));
    PRESET = 1'b0;
    m_ptr = 0;
    serve(1, 0, 32'h0F0F_0F0F, 1'b0, 4, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);

    // Randomized traffic; winner predicted from the model pointer and current requests.
    for (int it = 0; it < 200; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom() % 2 == 0))
          load(i, 1'($urandom()), $urandom(), $urandom(), 4'($urandom()), 3'($urandom()));
      end
      if (req == '0)
        load(int'($urandom() % N), 1'($urandom()), $urandom(), $urandom(), 4'($urandom()), 3'($urandom()));
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      waits = int'($urandom() % 5);
      prd   = $urandom();
      perr  = 1'($urandom());
      drop  = ($urandom() % 4 == 0);
      keep  = !drop && ($urandom() % 4 == 0);
      serve(w, waits, prd, perr, 4 + waits, prd, perr, drop, keep);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
